// File: rtl/arith_defs.sv
// Shared definitions for the arith_control_n unit.
// Provides the operation-select encodings used on the modo port.
package arith_defs;

    localparam logic [1:0] MODE_ADD  = 2'b00;
    localparam logic [1:0] MODE_SUB  = 2'b01;
    localparam logic [1:0] MODE_UP   = 2'b10;
    localparam logic [1:0] MODE_DOWN = 2'b11;

endpackage

// File: rtl/arith_core.sv
// Combinational unsigned add/subtract with one extra result bit.
// Ports:
//   x, y  : WIDTH-bit unsigned operands
//   sub   : 0 = x + y, 1 = x - y
//   full  : (WIDTH+1)-bit result
//   carry : carry out (add) or borrow, i.e. x < y (sub)
module arith_core #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             sub,
    output logic [WIDTH:0]   full,
    output logic             carry
);

    logic [WIDTH:0] x_ext;
    logic [WIDTH:0] y_ext;

    assign x_ext = {1'b0, x};
    assign y_ext = {1'b0, y};

    // With both operands zero-extended, the top bit of the difference is
    // exactly the borrow (x < y).
    assign full  = sub ? (x_ext - y_ext) : (x_ext + y_ext);
    assign carry = full[WIDTH];

endmodule

// File: rtl/arith_control_n.sv
// Registered WIDTH-bit arithmetic/counter unit.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   enb        : operation enable
//   clr        : synchronous clear (wins over enb)
//   modo       : ADD / SUB / UP / DOWN select
//   A, B       : unsigned operands for ADD/SUB
//   Q          : registered result
//   RCO        : carry/borrow pulse of the last enabled operation
//   OVF        : sticky overflow, set by any RCO
//   valid      : pulse marking Q/RCO updated by an enabled operation
module arith_control_n
    import arith_defs::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned STEP     = 1,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enb,
    input  logic             clr,
    input  logic [1:0]       modo,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Q,
    output logic             RCO,
    output logic             OVF,
    output logic             valid
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    logic [WIDTH-1:0] core_x;
    logic [WIDTH-1:0] core_y;
    logic             core_sub;
    logic [WIDTH:0]   core_full;
    logic             core_carry;

    logic [WIDTH-1:0] q_next;
    logic             rco_next;
    logic             ovf_next;
    logic             valid_next;

    // Counting modes operate on the current Q with the fixed step.
    always_comb begin
        core_x   = A;
        core_y   = B;
        core_sub = 1'b0;
        unique case (modo)
            MODE_ADD: begin
                core_x   = A;
                core_y   = B;
                core_sub = 1'b0;
            end
            MODE_SUB: begin
                core_x   = A;
                core_y   = B;
                core_sub = 1'b1;
            end
            MODE_UP: begin
                core_x   = Q;
                core_y   = STEP_W;
                core_sub = 1'b0;
            end
            MODE_DOWN: begin
                core_x   = Q;
                core_y   = STEP_W;
                core_sub = 1'b1;
            end
            default: begin
                core_x   = A;
                core_y   = B;
                core_sub = 1'b0;
            end
        endcase
    end

    arith_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .x    (core_x),
        .y    (core_y),
        .sub  (core_sub),
        .full (core_full),
        .carry(core_carry)
    );

    always_comb begin
        q_next     = Q;
        rco_next   = 1'b0;
        ovf_next   = OVF;
        valid_next = 1'b0;
        if (clr) begin
            q_next   = '0;
            ovf_next = 1'b0;
        end else if (enb) begin
            valid_next = 1'b1;
            rco_next   = core_carry;
            ovf_next   = OVF | core_carry;
            if (SATURATE && core_carry) begin
                // Clamp toward the direction of the overflow.
                q_next = core_sub ? '0 : '1;
            end else begin
                q_next = core_full[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Q     <= '0;
            RCO   <= 1'b0;
            OVF   <= 1'b0;
            valid <= 1'b0;
        end else begin
            Q     <= q_next;
            RCO   <= rco_next;
            OVF   <= ovf_next;
            valid <= valid_next;
        end
    end

endmodule

// File: tb/tb_arith_control_n.sv
// Directed bench for arith_control_n. Two instances share stimulus:
//   u_wrap : WIDTH=4, STEP=1, SATURATE=0
//   u_sat  : WIDTH=4, STEP=3, SATURATE=1
module tb_arith_control_n;

    logic       clk;
    logic       rst_n;
    logic       enb;
    logic       clr;
    logic [1:0] modo;
    logic [3:0] A;
    logic [3:0] B;

    logic [3:0] q0, q1;
    logic       rco0, rco1, ovf0, ovf1, valid0, valid1;

    int n_checks;
    int n_fail;

    arith_control_n #(
        .WIDTH(4), .STEP(1), .SATURATE(1'b0)
    ) u_wrap (
        .clk(clk), .rst_n(rst_n), .enb(enb), .clr(clr), .modo(modo),
        .A(A), .B(B), .Q(q0), .RCO(rco0), .OVF(ovf0), .valid(valid0)
    );

    arith_control_n #(
        .WIDTH(4), .STEP(3), .SATURATE(1'b1)
    ) u_sat (
        .clk(clk), .rst_n(rst_n), .enb(enb), .clr(clr), .modo(modo),
        .A(A), .B(B), .Q(q1), .RCO(rco1), .OVF(ovf1), .valid(valid1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge so outputs are sampled away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [1:0] m, input logic [3:0] a, input logic [3:0] b);
        clr  = 1'b0;
        enb  = 1'b1;
        modo = m;
        A    = a;
        B    = b;
        tick();
    endtask

    task automatic do_clr();
        clr = 1'b1;
        enb = 1'b0;
        tick();
        clr = 1'b0;
    endtask

    logic [3:0] e1;
    logic       r1;
    logic [4:0] s1;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        enb   = 1'b0;
        clr   = 1'b0;
        modo  = 2'b00;
        A     = '0;
        B     = '0;
        #22;
        check_eq("rst_q", {28'd0, q0}, 32'd0);
        check_eq("rst_flags", {28'd0, rco0, ovf0, valid0, valid1}, 32'd0);
        rst_n = 1'b1;
        #2;

        // Asynchronous reset mid-run with Q=9.
        op(2'b00, 4'd4, 4'd5);
        check_eq("pre_rst_q", {28'd0, q0}, 32'h9);
        enb = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_q", {28'd0, q0, q1}, 32'h0);
        check_eq("async_rst_flags", {28'd0, rco0, ovf0, valid0, rco1}, 32'd0);
        #1;
        rst_n = 1'b1;
        tick();
        tick();
        check_eq("rel_hold_q", {24'd0, q0, q1}, 32'h0);
        check_eq("rel_hold_flags", {26'd0, rco0, ovf0, valid0, rco1, ovf1, valid1}, 32'd0);

        // ADD/SUB boundaries.
        op(2'b00, 4'd7, 4'd8);
        check_eq("add_ff_q", {24'd0, q0, q1}, 32'hFF);
        check_eq("add_ff_rco", {29'd0, rco0, rco1, valid0}, 32'b001);
        op(2'b00, 4'd9, 4'd8);
        check_eq("add_ovf_q0", {28'd0, q0}, 32'h1);
        check_eq("add_ovf_q1_sat", {28'd0, q1}, 32'hF);
        check_eq("add_ovf_flags", {30'd0, rco0, ovf0}, 32'b11);
        op(2'b01, 4'd3, 4'd5);
        check_eq("sub_q0", {28'd0, q0}, 32'hE);
        check_eq("sub_q1_sat", {28'd0, q1}, 32'h0);
        check_eq("sub_rco", {30'd0, rco0, rco1}, 32'b11);

        // UP count with wrap; saturating instance modelled alongside.
        do_clr();
        check_eq("clr_q", {24'd0, q0, q1}, 32'h0);
        check_eq("clr_flags", {26'd0, rco0, ovf0, valid0, rco1, ovf1, valid1}, 32'd0);
        e1 = 4'd0;
        for (int i = 1; i <= 16; i++) begin
            op(2'b10, 4'd0, 4'd0);
            s1 = {1'b0, e1} + 5'd3;
            r1 = s1[4];
            e1 = r1 ? 4'hF : s1[3:0];
            check_eq($sformatf("up_q0_%0d", i), {28'd0, q0}, i % 16);
            check_eq($sformatf("up_rco0_%0d", i), {31'd0, rco0}, (i == 16) ? 32'd1 : 32'd0);
            check_eq($sformatf("up_valid_%0d", i), {31'd0, valid0}, 32'd1);
            check_eq($sformatf("up_sat_%0d", i), {27'd0, q1, rco1}, {27'd0, e1, r1});
        end
        check_eq("up_ovf0", {31'd0, ovf0}, 32'd1);

        // Saturation at the top and bottom.
        do_clr();
        op(2'b00, 4'd7, 4'd7);
        op(2'b10, 4'd0, 4'd0);
        check_eq("sat_up", {27'd0, q1, rco1}, {27'd0, 4'hF, 1'b1});
        check_eq("wrap_up_ef", {27'd0, q0, rco0}, {27'd0, 4'hF, 1'b0});
        op(2'b00, 4'd1, 4'd1);
        op(2'b11, 4'd0, 4'd0);
        check_eq("sat_down", {27'd0, q1, rco1}, {27'd0, 4'h0, 1'b1});
        check_eq("wrap_down_2", {27'd0, q0, rco0}, {27'd0, 4'h1, 1'b0});

        // DOWN at Q=0 borrows.
        do_clr();
        op(2'b11, 4'd0, 4'd0);
        check_eq("down_zero", {26'd0, q0, rco0, ovf0}, {26'd0, 4'hF, 1'b1, 1'b1});

        // clr wins over enb.
        do_clr();
        op(2'b00, 4'd9, 4'd8);
        op(2'b00, 4'd2, 4'd3);
        check_eq("prio_setup", {27'd0, q0, ovf0}, {27'd0, 4'h5, 1'b1});
        clr  = 1'b1;
        enb  = 1'b1;
        modo = 2'b10;
        tick();
        check_eq("prio_clr", {26'd0, q0, ovf0, valid0}, 32'd0);
        op(2'b10, 4'd0, 4'd0);
        check_eq("prio_next", {24'd0, q0, q1}, 32'h13);

        // Mode switch: ADD then DOWN from the ADD result, then hold.
        op(2'b00, 4'd4, 4'd4);
        check_eq("ms_add", {28'd0, q0}, 32'h8);
        op(2'b11, 4'd0, 4'd0);
        check_eq("ms_down1", {24'd0, q0, q1}, 32'h75);
        op(2'b11, 4'd0, 4'd0);
        check_eq("ms_down2", {24'd0, q0, q1}, 32'h62);
        enb = 1'b0;
        tick();
        check_eq("ms_hold_q", {24'd0, q0, q1}, 32'h62);
        check_eq("ms_hold_flags", {28'd0, rco0, valid0, rco1, valid1}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/arith_control_n.md
# arith_control_n

Parametrised, registered arithmetic/counter unit: the next generation of the 4-bit add/subtract control block. It is generalised to WIDTH bits and gains up/down counting modes, optional saturation, a sticky overflow flag, a synchronous clear and a result-valid strobe. It sits between the operand sources (A, B) and any consumer of Q/RCO. Cascaded instances chain through RCO.

## Interface
- WIDTH, 4, operand and result width in bits (≥2)
- STEP, 1, increment/decrement amount for counting modes (1 ≤ STEP < 2^WIDTH)
- SATURATE, 0, 0 = wrap on carry/borrow, 1 = clamp to 2^WIDTH−1 / 0
- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- enb  input  1  operation enable, sampled each rising edge
- clr  input  1  synchronous clear of Q, RCO, OVF, valid
- modo  input  2  operation select (see Operation)
- A  input  WIDTH  operand A, unsigned
- B  input  WIDTH  operand B, unsigned
- Q  output  WIDTH  registered result
- RCO  output  1  registered carry/borrow/wrap pulse for the last operation
- OVF  output  1  sticky: set when any RCO is produced
- valid  output  1  one-cycle pulse: Q/RCO updated by an enabled operation

## Operation
- Reset (rst_n low, asynchronous): Q=0, RCO=0, OVF=0, valid=0. Held while low. First operation is sampled on the first rising edge with rst_n high.
- Priority per edge: clr > enb > hold.
- clr=1: Q=0, RCO=0, OVF=0, valid=0. enb and modo are ignored that cycle.
- enb=0, clr=0: Q and OVF hold. RCO=0, valid=0.
- enb=1, clr=0: valid=1. Operation by modo:
  - 00 ADD: full = A+B (WIDTH+1 bits). RCO = full[WIDTH].
  - 01 SUB: full = A−B. RCO = (A<B), i.e. borrow.
  - 10 UP: full = Q+STEP. RCO = carry out.
  - 11 DOWN: full = Q−STEP. RCO = (Q<STEP).
- Result with SATURATE=0: Q = full[WIDTH−1:0] (wrap).
- Result with SATURATE=1 and RCO=1: Q = 2^WIDTH−1 for ADD/UP and Q = 0 for SUB/DOWN. RCO still asserts.
- OVF is set whenever RCO is set. It is cleared only by clr or reset.
- modo may change on any cycle and takes effect on the next enabled edge. The counting modes use the current Q, including a Q produced by ADD/SUB.
- All arithmetic is unsigned. No X may propagate from unused upper bits.

## Timing
- Latency: 1 cycle. Operands and modo sampled at edge N appear on Q/RCO/valid after edge N.
- RCO and valid are single-cycle pulses per enabled edge. With enb held high, they may stay high on consecutive cycles.
- Continuous enb with UP: one count per clock, no bubbles.
- Reset asserted mid-operation: outputs go to their reset values immediately, without waiting for a clock edge. No pending result survives.
- Boundaries:
  - UP at Q = 2^WIDTH−STEP: wraps to 0 with RCO=1 (SATURATE=0).
  - UP at Q = 2^WIDTH−1: clamps with RCO=1 (SATURATE=1).
  - DOWN at Q=0 gives RCO=1.
  - ADD with A+B = 2^WIDTH−1 exactly gives RCO=0.

## Structure
- Shared include/package `arith_defs`: mode constants MODE_ADD=2'b00, MODE_SUB=2'b01, MODE_UP=2'b10, MODE_DOWN=2'b11.
- Sub-module `arith_core`: combinational WIDTH-bit add/subtract with (WIDTH+1)-bit result. Inputs: x, y, sub. Outputs: full sum and carry/borrow. The top selects x/y (A/B or Q/STEP) and applies saturation and the registers.

## Test plan
- Reset/hold: rst_n low mid-run with Q=4'h9 → Q=0, RCO=0, OVF=0, valid=0 without a clock edge. Release with enb=0 → all outputs stay 0.
- ADD/SUB (WIDTH=4): A=7,B=8 ADD → Q=4'hF, RCO=0. A=9,B=8 ADD → Q=1, RCO=1, OVF=1. A=3,B=5 SUB → Q=4'hE, RCO=1.
- UP wrap (STEP=1, SATURATE=0): start Q=0, enb=1 for 16 cycles → Q counts 1..F then 0. RCO=1 only on the edge Q goes F→0. valid high every cycle.
- Saturation (SATURATE=1, STEP=3): Q=4'hE, UP → Q=4'hF, RCO=1. Q=2, DOWN → Q=0, RCO=1.
- Priority: clr=1 and enb=1 with modo=UP, Q=5, OVF=1 → Q=0, OVF=0, valid=0. Next cycle, enb only → Q=1.
- Mode switch: ADD A=4,B=4 → Q=8. Then DOWN STEP=1 for 2 cycles → Q=7, then 6. enb=0 → Q holds 6, RCO=0, valid=0.
